// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types for the L1 miss-path memory arbiter
package cache_mem_arbiter_pkg;

  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_priority.sv
// rtl/cache_mem_arbiter_priority.sv - next-owner selection and D-streak update
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter_priority #(
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic [2:0] streak_i,
  output logic       grant_o,
  output arb_owner_t owner_o,
  output logic [2:0] streak_o
);

  // D wins until it has taken MAX_D_STREAK grants in a row over a waiting I.
  always_comb begin
    grant_o  = 1'b0;
    owner_o  = OWN_D;
    streak_o = streak_i;
    if (d_req_i && i_req_i) begin
      grant_o = 1'b1;
      if (streak_i < 3'(MAX_D_STREAK)) begin
        owner_o  = OWN_D;
        streak_o = streak_i + 3'd1;
      end else begin
        owner_o  = OWN_I;
        streak_o = '0;
      end
    end else if (d_req_i) begin
      grant_o  = 1'b1;
      owner_o  = OWN_D;
      streak_o = '0;
    end else if (i_req_i) begin
      grant_o  = 1'b1;
      owner_o  = OWN_I;
      streak_o = '0;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares the cacheline adaptor between I-cache and D-cache misses
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = LINE_W,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t            state_q, state_d;
  logic [2:0]            streak_q, streak_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_resp_q, i_resp_d;
  logic                  d_resp_q, d_resp_d;

  logic       grant;
  arb_owner_t next_owner;
  logic [2:0] streak_next;

  cache_mem_arbiter_priority #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_priority (
    .i_req_i (i_read),
    .d_req_i (d_read | d_write),
    .streak_i(streak_q),
    .grant_o (grant),
    .owner_o (next_owner),
    .streak_o(streak_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          streak_d = streak_next;
          if (next_owner == OWN_D) begin
            // A write wins if both D ops are (illegally) raised together.
            state_d     = SERVE_D;
            mem_write_d = d_write;
            mem_read_d  = ~d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = SERVE_I;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = i_addr;
          end
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_d    = RESP;
          mem_read_d = 1'b0;
          i_rdata_d  = mem_rdata;
          i_resp_d   = 1'b1;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_rdata_d   = mem_rdata;
          d_resp_d    = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;

  illegal_d_op: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, mem_resp;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] d_wdata, mem_rdata;
  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;
  logic [31:0]  mem_addr;

  int checks = 0;
  int fails  = 0;
  logic [255:0] exp_i_rdata;

  cache_mem_arbiter #(
    .ADDR_WIDTH(32),
    .LINE_WIDTH(256),
    .MAX_D_STREAK(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] mdata;
    int           lat;
    logic         exp_rd;
    logic         exp_wr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_read || mem_write) && cyc < 20);
    if (cyc >= 20) chk("grant_timeout", 0, 1);
  endtask

  // Adaptor model: called at the negedge of the first mem_* cycle, returns at the RESP negedge.
  task automatic run_xfer(input int lat, input logic [255:0] data, input logic exp_rd,
                          input logic exp_wr, input logic [31:0] exp_addr,
                          input logic [255:0] exp_wdata, input bit glitch_i);
    for (int k = 1; k <= lat; k++) begin
      chk("mem_read_held", mem_read, exp_rd);
      chk("mem_write_held", mem_write, exp_wr);
      chk("mem_addr_held", mem_addr, exp_addr);
      if (exp_wr) chk("mem_wdata_held", mem_wdata, exp_wdata);
      chk("no_early_resp", i_resp | d_resp, 0);
      if (glitch_i && k == 1) i_read = 1'b1;
      if (glitch_i && k == 2) i_read = 1'b0;
      if (k == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = data;
      end
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = {8{32'h0BAD_F00D}};
    end
    chk("mem_read_dropped", mem_read, 0);
    chk("mem_write_dropped", mem_write, 0);
  endtask

  initial begin
    int cyc;
    logic [255:0] d_data;
    logic [31:0]  a_i, a_d;
    arb_order_t_dummy: begin end

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0140, '0, {32{8'hA5}}, 4, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, {32{8'h3C}}, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h8000_0020, {8{32'hDEAD_BEEF}}, {32{8'h77}}, 3, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, '0, {8{32'h1234_5678}}, 2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, {16{16'hC0DE}}, 6, 1'b1, 1'b0};

    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    exp_i_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp", i_resp | d_resp, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // Reset in the middle of a writeback.
    d_write = 1'b1; d_addr = 32'h0000_0300; d_wdata = {8{32'h5555_AAAA}};
    wait_grant(cyc);
    chk("rstmid_mem_write", mem_write, 1);
    @(negedge clk);
    rst = 1'b1; d_write = 1'b0;
    @(negedge clk);
    chk("rstmid_write_dropped", mem_write, 0);
    chk("rstmid_read_dropped", mem_read, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_still_idle", mem_write | mem_read, 0);
    d_write = 1'b1;
    wait_grant(cyc);
    chk("rstmid_regrant_lat", cyc, 1);
    run_xfer(1, '0, 1'b0, 1'b1, 32'h0000_0300, {8{32'h5555_AAAA}}, 1'b0);
    chk("rstmid_d_resp", d_resp, 1);
    d_write = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      i_read = vecs[v].i_rd; d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
      i_addr = vecs[v].i_rd ? vecs[v].addr : 32'h1111_1100;
      d_addr = vecs[v].i_rd ? 32'h2222_2200 : vecs[v].addr;
      d_wdata = vecs[v].wdata;
      wait_grant(cyc);
      chk("vec_grant_lat", cyc, 1);
      run_xfer(vecs[v].lat, vecs[v].mdata, vecs[v].exp_rd, vecs[v].exp_wr,
               vecs[v].addr, vecs[v].wdata, 1'b0);
      chk("vec_i_resp", i_resp, vecs[v].i_rd);
      chk("vec_d_resp", d_resp, !vecs[v].i_rd);
      if (vecs[v].i_rd) begin
        exp_i_rdata = vecs[v].mdata;
        chk("vec_i_rdata", i_rdata, exp_i_rdata);
      end else begin
        chk("vec_i_rdata_hold", i_rdata, exp_i_rdata);
        if (vecs[v].d_rd) chk("vec_d_rdata", d_rdata, vecs[v].mdata);
      end
      i_read = 0; d_read = 0; d_write = 0;
      @(negedge clk);
      chk("vec_single_pulse", i_resp | d_resp, 0);
      @(negedge clk);
      chk("vec_idle_after", mem_read | mem_write, 0);
    end

    // Simultaneous I and D: D first, then I right after the RESP/IDLE pair.
    a_i = 32'h0000_0A00; a_d = 32'h0000_0D00;
    i_read = 1; i_addr = a_i; d_read = 1; d_addr = a_d;
    wait_grant(cyc);
    chk("sim_d_first_addr", mem_addr, a_d);
    d_data = {4{64'hFEED_FACE_CAFE_0001}};
    run_xfer(2, d_data, 1'b1, 1'b0, a_d, '0, 1'b0);
    chk("sim_d_resp", d_resp, 1);
    chk("sim_d_rdata", d_rdata, d_data);
    chk("sim_no_i_resp", i_resp, 0);
    d_read = 0;
    wait_grant(cyc);
    chk("sim_i_gap", cyc, 2);
    chk("sim_i_addr", mem_addr, a_i);
    run_xfer(1, {32{8'h5A}}, 1'b1, 1'b0, a_i, '0, 1'b0);
    chk("sim_i_resp", i_resp, 1);
    chk("sim_i_rdata", i_rdata, {32{8'h5A}});
    exp_i_rdata = {32{8'h5A}};
    i_read = 0;
    @(negedge clk);

    // Both held continuously: streak limit gives D, D, I, D, D, I.
    i_read = 1; d_read = 1;
    for (int g = 0; g < 6; g++) begin
      logic exp_d;
      exp_d = (g % 3) != 2;
      wait_grant(cyc);
      chk("streak_owner", mem_addr, exp_d ? a_d : a_i);
      run_xfer(1, {8{32'(g)}}, 1'b1, 1'b0, exp_d ? a_d : a_i, '0, 1'b0);
      chk("streak_d_resp", d_resp, exp_d);
      chk("streak_i_resp", i_resp, !exp_d);
    end
    i_read = 0; d_read = 0;
    repeat (2) @(negedge clk);
    exp_i_rdata = {8{32'(5)}};
    chk("streak_i_rdata", i_rdata, exp_i_rdata);

    // Spurious mem_resp in IDLE, then an i_read glitch during SERVE_D.
    mem_resp = 1; mem_rdata = {32{8'hEE}};
    @(negedge clk);
    mem_resp = 0;
    chk("spur_no_resp", i_resp | d_resp, 0);
    chk("spur_no_grant", mem_read | mem_write, 0);
    chk("spur_i_rdata", i_rdata, exp_i_rdata);
    d_read = 1; d_addr = 32'h0000_0E40; i_addr = 32'h0000_0F80;
    wait_grant(cyc);
    run_xfer(4, {32{8'h11}}, 1'b1, 1'b0, 32'h0000_0E40, '0, 1'b1);
    chk("glitch_d_resp", d_resp, 1);
    d_read = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("glitch_no_grant", mem_read | mem_write, 0);
      chk("glitch_no_i_resp", i_resp, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
